// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the instruction-fetch
// port (read only) and the data load/store port. One transaction at a time:
// IDLE -> ISSUE -> WAIT -> DONE -> IDLE, round-robin on simultaneous requests.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1   // cycles from the MemRd edge to valid data, 1..15
) (
  input  logic              clk,
  input  logic              reset,
  // instruction-fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  // data port
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  // memory side
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              MemRd,
  output logic              MemWr,
  output logic              MemEnable,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;

  // WAIT lasts MEM_LAT cycles; the counter is loaded in ISSUE and the data
  // is captured when it reaches zero.
  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  logic [1:0]        state_reg;
  logic              last_grant_reg;
  logic              winner_reg;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [3:0]        cnt_reg;
  logic [DATA_W-1:0] if_rdata_reg;
  logic [DATA_W-1:0] dm_rdata_reg;

  logic              grant_dm;

  // Arbitration: a lone requester wins; on a tie the port that was not
  // granted last time wins (last_grant resets to IF, so DM takes the first tie).
  always_comb begin
    grant_dm = dm_req & (~if_req | (last_grant_reg == PORT_IF));
  end

  // Transaction sequencer: latches the winner's request at grant and walks
  // it through issue, latency wait and acknowledge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= PORT_IF;
      winner_reg     <= PORT_IF;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      cnt_reg        <= '0;
      if_rdata_reg   <= '0;
      dm_rdata_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (if_req | dm_req) begin
            winner_reg <= grant_dm ? PORT_DM : PORT_IF;
            we_reg     <= grant_dm & dm_we;
            addr_reg   <= grant_dm ? dm_addr : if_addr;
            wdata_reg  <= grant_dm ? dm_wdata : '0;
            state_reg  <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_reg   <= CNT_INIT;
          state_reg <= WAIT;
        end
        WAIT: begin
          if (cnt_reg == 4'd0) begin
            // Only reads update the winner's data register; writes leave
            // both read-data registers untouched.
            if (!we_reg) begin
              if (winner_reg == PORT_DM) begin
                dm_rdata_reg <= mem_data_out;
              end else begin
                if_rdata_reg <= mem_data_out;
              end
            end
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        default: begin  // DONE
          last_grant_reg <= winner_reg;
          state_reg      <= IDLE;
        end
      endcase
    end
  end

  // Memory strobes are decoded from the state so read and write can only be
  // asserted in ISSUE and never together; enable covers the whole access.
  always_comb begin
    MemEnable   = (state_reg == ISSUE) || (state_reg == WAIT);
    MemRd       = (state_reg == ISSUE) && !we_reg;
    MemWr       = (state_reg == ISSUE) && we_reg;
    mem_address = addr_reg;
    mem_data_in = wdata_reg;
    if_ack      = (state_reg == DONE) && (winner_reg == PORT_IF);
    dm_ack      = (state_reg == DONE) && (winner_reg == PORT_DM);
    busy        = (state_reg != IDLE);
    if_rdata    = if_rdata_reg;
    dm_rdata    = dm_rdata_reg;
  end

endmodule
